// File: rtl/boreal_kalman_sched_if.sv
// Observation, MMIO and result signals of boreal_kalman_sched.
// The master modport drives observations and config; the slave modport is the scheduler.
interface boreal_kalman_sched_if #(
    parameter int NCH = 4,
    parameter int CHW = 2
);
    logic [NCH-1:0]     in_valid;
    logic [NCH-1:0]     in_ready;
    logic [24*NCH-1:0]  in_z;
    logic               cfg_we;
    logic [CHW+1:0]     cfg_addr;
    logic [15:0]        cfg_wdata;
    logic               out_valid;
    logic [CHW-1:0]     out_ch;
    logic signed [23:0] out_x;
    logic               busy;

    modport master (
        output in_valid, in_z, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_ch, out_x, busy
    );

    modport slave (
        input  in_valid, in_z, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_ch, out_x, busy
    );
endinterface

// File: rtl/boreal_kalman_sched.sv
// Q15 per-channel state estimator sharing one 24x16 multiplier across NCH channels.
// Define KSCHED_FIXED_PRIO_EN for lowest-index-first arbitration instead of round-robin.
module boreal_kalman_sched #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    boreal_kalman_sched_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRED  = 3'd1;
    localparam logic [2:0] S_OBS   = 3'd2;
    localparam logic [2:0] S_INNOV = 3'd3;
    localparam logic [2:0] S_CORR  = 3'd4;
    localparam logic [2:0] S_UPD   = 3'd5;

    function automatic logic signed [23:0] sat24(input logic signed [39:0] v);
        if (v > 40'sd8388607)       return 24'sh7FFFFF;
        else if (v < -40'sd8388608) return 24'sh800000;
        else                        return v[23:0];
    endfunction

    logic [2:0]         r_state;
    logic [NCH-1:0]     r_pend;
    logic signed [23:0] r_buf   [NCH];
    logic signed [23:0] r_xprev [NCH];
    logic signed [15:0] r_coef_a [NCH];
    logic signed [15:0] r_coef_h [NCH];
    logic signed [15:0] r_coef_k [NCH];
    logic [CHW-1:0]     r_ch;
    logic signed [23:0] r_z, r_x0, r_xp, r_t;
    logic signed [15:0] r_a, r_h, r_k;
    logic               r_discard;
    logic               r_out_valid;
    logic [CHW-1:0]     r_out_ch;
    logic signed [23:0] r_out_x;

    logic [CHW-1:0]     w_base;
    logic [CHW-1:0]     w_gnt_ch;
    logic               w_gnt_found;
    logic signed [23:0] w_mul_a;
    logic signed [15:0] w_mul_b;
    logic signed [39:0] w_prod, w_shift;
    logic signed [23:0] w_mul_res;
    logic signed [24:0] w_diff, w_sum;
    logic [CHW-1:0]     w_cfg_ch;
    logic [1:0]         w_cfg_reg;
    logic               w_clr;

`ifdef KSCHED_FIXED_PRIO_EN
    assign w_base = '1;
`else
    logic [CHW-1:0] r_last;
    assign w_base = r_last;
`endif

    // Scan from base+NCH down to base+1 so the nearest pending channel after base wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_ch    = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (r_pend[w_base + CHW'(k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_ch    = w_base + CHW'(k);
            end
        end
    end

    always_comb begin
        w_mul_a = r_x0;
        w_mul_b = r_a;
        case (r_state)
            S_OBS:   begin w_mul_a = r_xp; w_mul_b = r_h; end
            S_CORR:  begin w_mul_a = r_t;  w_mul_b = r_k; end
            default: ;
        endcase
    end

    assign w_prod    = w_mul_a * w_mul_b;
    assign w_shift   = w_prod >>> 15;
    assign w_mul_res = sat24(w_shift);
    assign w_diff    = {r_z[23], r_z} - {r_t[23], r_t};
    assign w_sum     = {r_xp[23], r_xp} + {r_t[23], r_t};

    assign w_cfg_ch  = bus.cfg_addr[CHW+1:2];
    assign w_cfg_reg = bus.cfg_addr[1:0];
    assign w_clr     = bus.cfg_we && (w_cfg_reg == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pend      <= '0;
            r_ch        <= '0;
            r_z         <= '0;
            r_x0        <= '0;
            r_xp        <= '0;
            r_t         <= '0;
            r_a         <= '0;
            r_h         <= '0;
            r_k         <= '0;
            r_discard   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_x     <= '0;
`ifndef KSCHED_FIXED_PRIO_EN
            r_last      <= CHW'(NCH - 1);
`endif
            for (int i = 0; i < NCH; i++) begin
                r_buf[i]    <= '0;
                r_xprev[i]  <= '0;
                r_coef_a[i] <= 16'sh7FFF;
                r_coef_h[i] <= 16'sh7FFF;
                r_coef_k[i] <= 16'sh4000;
            end
        end else begin
            r_out_valid <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (bus.in_valid[i] && !r_pend[i]) begin
                    r_pend[i] <= 1'b1;
                    r_buf[i]  <= bus.in_z[24*i +: 24];
                end
            end

            case (r_state)
                S_IDLE: if (w_gnt_found) begin
                    r_ch             <= w_gnt_ch;
                    r_z              <= r_buf[w_gnt_ch];
                    r_x0             <= r_xprev[w_gnt_ch];
                    r_a              <= r_coef_a[w_gnt_ch];
                    r_h              <= r_coef_h[w_gnt_ch];
                    r_k              <= r_coef_k[w_gnt_ch];
                    r_pend[w_gnt_ch] <= 1'b0;
                    r_discard        <= w_clr && (w_cfg_ch == w_gnt_ch);
`ifndef KSCHED_FIXED_PRIO_EN
                    r_last           <= w_gnt_ch;
`endif
                    r_state          <= S_PRED;
                end
                S_PRED:  begin r_xp <= w_mul_res; r_state <= S_OBS;   end
                S_OBS:   begin r_t  <= w_mul_res; r_state <= S_INNOV; end
                S_INNOV: begin r_t  <= sat24({{15{w_diff[24]}}, w_diff}); r_state <= S_CORR; end
                S_CORR:  begin r_t  <= w_mul_res; r_state <= S_UPD;   end
                S_UPD: begin
                    r_out_valid <= 1'b1;
                    r_out_ch    <= r_ch;
                    r_out_x     <= sat24({{15{w_sum[24]}}, w_sum});
                    if (!r_discard) r_xprev[r_ch] <= sat24({{15{w_sum[24]}}, w_sum});
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Placed after the writeback so a same-cycle clear of that channel wins.
            if (bus.cfg_we) begin
                case (w_cfg_reg)
                    2'd0: r_coef_a[w_cfg_ch] <= bus.cfg_wdata;
                    2'd1: r_coef_h[w_cfg_ch] <= bus.cfg_wdata;
                    2'd2: r_coef_k[w_cfg_ch] <= bus.cfg_wdata;
                    default: begin
                        r_xprev[w_cfg_ch] <= '0;
                        if (r_state != S_IDLE && w_cfg_ch == r_ch) r_discard <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = ~r_pend;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_x     = r_out_x;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_boreal_kalman_sched.sv
// Self-checking bench for boreal_kalman_sched: directed scenarios plus randomized bursts
// compared against an arithmetic reference of the estimator and the arbitration order.
`timescale 1ns/1ps
module tb_boreal_kalman_sched;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    boreal_kalman_sched_if #(.NCH(NCH), .CHW(CHW)) bus();
    boreal_kalman_sched #(.NCH(NCH), .CHW(CHW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    longint m_x [NCH];
    longint m_a [NCH];
    longint m_h [NCH];
    longint m_k [NCH];
    int     m_last;

    function automatic longint sat24(input longint v);
        if (v > 8388607)  return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    // floor(p / 2^15) with plain division, independent of shift semantics
    function automatic longint q15(input longint p);
        longint r;
        r = p % 32768;
        if (r < 0) r += 32768;
        return (p - r) / 32768;
    endfunction

    function automatic longint model_update(input int ch, input longint z);
        longint xp, zp, y, c, xn;
        xp = sat24(q15(m_x[ch] * m_a[ch]));
        zp = sat24(q15(xp * m_h[ch]));
        y  = sat24(z - zp);
        c  = sat24(q15(y * m_k[ch]));
        xn = sat24(xp + c);
        m_x[ch] = xn;
        m_last  = ch;
        return xn;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_x[i] = 0; m_a[i] = 32767; m_h[i] = 32767; m_k[i] = 16384;
        end
        m_last = NCH - 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = '0;
        bus.cfg_we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called at a negedge; the observation is accepted at the following edge (E0).
    task automatic send(input int ch, input longint z);
        bus.in_valid[ch] = 1'b1;
        bus.in_z[24*ch +: 24] = 24'(z);
        @(posedge clk);
        #1 bus.in_valid = '0;
    endtask

    task automatic cfg_write(input int ch, input int rg, input logic [15:0] data);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = {CHW'(ch), 2'(rg)};
        bus.cfg_wdata = data;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        case (rg)
            0: m_a[ch] = longint'($signed(data));
            1: m_h[ch] = longint'($signed(data));
            2: m_k[ch] = longint'($signed(data));
            default: m_x[ch] = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic wait_out(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 4'b1111) begin errors++; $display("FAIL reset_in_ready got %b want 1111", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.out_x !== 24'sd0 || bus.out_ch !== 2'd0) begin errors++; $display("FAIL reset_out got ch %0d x %0d want 0 0", bus.out_ch, bus.out_x); end
    endtask

    task automatic test_basic();
        int n; bit ok; longint e;
        apply_reset();
        send(0, 1000);
        checks++; if (bus.in_ready[0] !== 1'b0) begin errors++; $display("FAIL basic_pend got %b want 0", bus.in_ready[0]); end
        @(posedge clk); #1;
        checks++; if (bus.in_ready[0] !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_grant got ready %b busy %b want 1 1", bus.in_ready[0], bus.busy); end
        e = model_update(0, 1000);
        wait_out(n, ok);
        checks++; if (!ok || n != 6) begin errors++; $display("FAIL basic_latency got %0d want 6 after grant", n); end
        checks++; if (bus.out_ch !== 2'd0 || bus.out_x !== 24'sd500) begin errors++; $display("FAIL basic_x1 got ch %0d x %0d want 0 500", bus.out_ch, bus.out_x); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_pulse got valid %b busy %b want 0 0", bus.out_valid, bus.busy); end
        send(0, 1000);
        e = model_update(0, 1000);
        wait_out(n, ok);
        checks++; if (!ok || bus.out_x !== 24'sd750) begin errors++; $display("FAIL basic_x2 got %0d want 750 (model %0d)", bus.out_x, e); end
    endtask

    task automatic test_burst();
        int n; bit ok; longint e;
        apply_reset();
        for (int i = 0; i < NCH; i++) begin
            bus.in_valid[i] = 1'b1;
            bus.in_z[24*i +: 24] = 24'(4000 * (i + 1));
        end
        @(posedge clk);
        #1 bus.in_valid = '0;
        for (int i = 0; i < NCH; i++) begin
            e = model_update(i, 4000 * (i + 1));
            wait_out(n, ok);
            checks++;
            if (!ok || n != (i == 0 ? 7 : 6) || bus.out_ch !== 2'(i) || bus.out_x !== 24'(2000 * (i + 1))) begin
                errors++;
                $display("FAIL burst_%0d got ch %0d x %0d gap %0d want ch %0d x %0d gap %0d", i, bus.out_ch, bus.out_x, n, i, 2000 * (i + 1), (i == 0 ? 7 : 6));
            end
        end
    endtask

    task automatic test_sat();
        int n; bit ok; longint e;
        apply_reset();
        cfg_write(1, 2, 16'h7FFF);
        send(1, 8388607);
        e = model_update(1, 8388607);
        wait_out(n, ok);
        checks++; if (!ok || bus.out_x !== 24'sd8388351) begin errors++; $display("FAIL sat_pos got %0d want 8388351", bus.out_x); end
        send(1, -8388608);
        e = model_update(1, -8388608);
        wait_out(n, ok);
        checks++; if (!ok || bus.out_x !== -24'sd257) begin errors++; $display("FAIL sat_neg got %0d want -257", bus.out_x); end
    endtask

    task automatic test_clear_in_flight();
        int n; bit ok; longint e;
        apply_reset();
        send(2, 1000);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b1;
        bus.cfg_addr = {2'd2, 2'd3};
        bus.cfg_wdata = 16'h1234;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        e = model_update(2, 1000);
        m_x[2] = 0;
        wait_out(n, ok);
        checks++; if (!ok || bus.out_ch !== 2'd2 || bus.out_x !== 24'sd500) begin errors++; $display("FAIL clr_emit got ch %0d x %0d want 2 500", bus.out_ch, bus.out_x); end
        send(2, 1000);
        e = model_update(2, 1000);
        wait_out(n, ok);
        checks++; if (!ok || bus.out_x !== 24'sd500) begin errors++; $display("FAIL clr_state got %0d want 500", bus.out_x); end
    endtask

    task automatic test_reset_mid();
        int n; bit ok; bit seen; longint e;
        @(negedge clk);
        bus.in_valid[3] = 1'b1;
        bus.in_z[24*3 +: 24] = 24'(777);
        send(0, 1000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 4'b1111 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got busy %b ready %b valid %b want 0 1111 0", bus.busy, bus.in_ready, bus.out_valid); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_no_output got out_valid 1 want 0"); end
        send(0, 1000);
        e = model_update(0, 1000);
        wait_out(n, ok);
        checks++; if (!ok || bus.out_x !== 24'sd500 || n != 7) begin errors++; $display("FAIL rstmid_after got x %0d gap %0d want 500 7", bus.out_x, n); end
    endtask

    task automatic test_priority();
        int n; bit ok; longint e;
        apply_reset();
        bus.in_valid[3] = 1'b1;
        bus.in_z[24*3 +: 24] = 24'(600);
        send(1, 300);
        e = model_update(1, 300);
        wait_out(n, ok);
        checks++; if (!ok || bus.out_ch !== 2'd1 || bus.out_x !== 24'(e)) begin errors++; $display("FAIL prio_first got ch %0d x %0d want 1 %0d", bus.out_ch, bus.out_x, e); end
        e = model_update(3, 600);
        wait_out(n, ok);
        checks++; if (!ok || bus.out_ch !== 2'd3 || bus.out_x !== 24'(e) || n != 6) begin errors++; $display("FAIL prio_second got ch %0d x %0d gap %0d want 3 %0d 6", bus.out_ch, bus.out_x, n, e); end
    endtask

    task automatic test_coef_snapshot();
        int n; bit ok; longint e;
        apply_reset();
        send(0, 1000);
        e = model_update(0, 1000);
        wait_out(n, ok);
        send(0, 2000);
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b1;
        bus.cfg_addr = {2'd0, 2'd0};
        bus.cfg_wdata = 16'h4000;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        e = model_update(0, 2000);
        m_a[0] = 16384;
        wait_out(n, ok);
        checks++; if (!ok || bus.out_x !== 24'(e)) begin errors++; $display("FAIL snap_old got %0d want %0d", bus.out_x, e); end
        send(0, 2000);
        e = model_update(0, 2000);
        wait_out(n, ok);
        checks++; if (!ok || bus.out_x !== 24'(e)) begin errors++; $display("FAIL snap_new got %0d want %0d", bus.out_x, e); end
    endtask

    task automatic test_random();
        int n; bit ok; longint e;
        int order[$];
        longint zs [NCH];
        logic [NCH-1:0] mask;
        logic signed [23:0] zv;
        apply_reset();
        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(0, 2)) cfg_write($urandom_range(0, NCH - 1), $urandom_range(0, 3), 16'($urandom));
            mask = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int c = 0; c < NCH; c++) begin
                case ($urandom_range(0, 5))
                    0:       zv = 24'sh7FFFFF;
                    1:       zv = 24'sh800000;
                    default: zv = 24'($urandom);
                endcase
                zs[c] = zv;
                bus.in_z[24*c +: 24] = zv;
            end
            order.delete();
`ifdef KSCHED_FIXED_PRIO_EN
            for (int c = 0; c < NCH; c++) if (mask[c]) order.push_back(c);
`else
            for (int k = 1; k <= NCH; k++) if (mask[(m_last + k) % NCH]) order.push_back((m_last + k) % NCH);
`endif
            bus.in_valid = mask;
            @(posedge clk);
            #1 bus.in_valid = '0;
            for (int j = 0; j < order.size(); j++) begin
                e = model_update(order[j], zs[order[j]]);
                wait_out(n, ok);
                checks++;
                if (!ok || n != (j == 0 ? 7 : 6) || bus.out_ch !== 2'(order[j]) || bus.out_x !== 24'(e)) begin
                    errors++;
                    $display("FAIL rand_r%0d_%0d got ch %0d x %0d gap %0d want ch %0d x %0d gap %0d", r, j, bus.out_ch, bus.out_x, n, order[j], e, (j == 0 ? 7 : 6));
                end
            end
        end
    endtask

    initial begin
        bus.in_valid = '0;
        bus.in_z = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_wdata = '0;
        test_reset();
        test_basic();
        test_burst();
        test_sat();
        test_clear_in_flight();
        test_reset_mid();
        test_priority();
        test_coef_snapshot();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/boreal_kalman_sched.md
Name: boreal_kalman_sched

Overview:
- Time-multiplexes one Q15 latent-state estimator datapath (predict / observe / innovate / correct / update) across NCH feature channels, e.g. the CSP outputs.
- Holds per-channel state x_prev and per-channel A/H/K coefficients, written over MMIO.
- Buffers one observation per channel and arbitrates round-robin.
- Sequences a single shared 24x16 signed multiplier through the three multiply steps of each update.

Parameters:
- NCH, 4: number of channels; power of 2, 2..16.
- CHW, 2: channel index width; equals log2(NCH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  NCH  per-channel observation valid
- in_ready  out  NCH  per-channel ready; in_ready[i] = ~pend[i]
- in_z  in  24*NCH  signed observations; channel i occupies [24*i+23:24*i]
- cfg_we  in  1  MMIO write strobe
- cfg_addr  in  CHW+2  {channel, reg}; reg 0=A, 1=H, 2=K, 3=state clear (data ignored)
- cfg_wdata  in  16  signed Q15 coefficient
- out_valid  out  1  one-cycle result strobe
- out_ch  out  CHW  channel of the result
- out_x  out  24  signed updated state x(t|t)
- busy  out  1  engine not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - out_valid=0, out_ch=0, out_x=0, busy=0.
  - All pend=0, so all in_ready=1.
  - All x_prev=0.
  - A=H=16'h7FFF, K=16'h4000 for every channel.
  - last_grant=NCH-1.
  - FSM=IDLE.
- Accept: in_valid[i]&in_ready[i] at an edge latches in_z[i] into buf[i] and sets pend[i]. No overwrite while pend[i] is set.
- FSM:
  - IDLE: if any pend, grant the first pending channel searching from last_grant+1 with wrap. Snapshot ch, z, x_prev, A, H, K. Clear pend[ch]; update last_grant; go to PRED.
  - PRED: xp = sat24((x_prev*A)>>>15).
  - OBS: zp = sat24((xp*H)>>>15).
  - INNOV: y = sat24(z - zp), computed at 25 bits.
  - CORR: c = sat24((y*K)>>>15).
  - UPD: xn = sat24(xp + c). Write x_prev[ch]=xn unless discarded (see state clear). out_valid=1, out_ch=ch, out_x=xn. Go to IDLE.
- Arithmetic: products are 40-bit signed; >>> is arithmetic, i.e. floor. sat24 clamps to [-8388608, 8388607].
- Multiplier: exactly one multiplier instance, operands muxed by state.
- Latency and throughput:
  - Accept at edge E0, grant at E1, out_valid high after E6 when the engine is idle.
  - One result per 6 cycles.
  - The granted channel shows in_ready=1 from the cycle after grant.
- Config:
  - Coefficient writes take effect on the next grant of that channel; the in-flight snapshot is unaffected.
  - State clear sets x_prev[ch]=0.
  - If that channel is in flight (E1..E6), its UPD writeback is discarded. The output is still emitted.
  - A clear and a writeback to the same channel in the same cycle: the clear wins.
- out_valid deasserts the cycle after UPD. There is no output backpressure.
- rst_n low mid-operation: abort immediately and restore all reset values. Pending samples are lost and no out_valid is produced.

Optional Feature:
- Macro: KSCHED_FIXED_PRIO_EN.
- Defined: the grant picks the lowest-index pending channel (channel 0 highest priority). last_grant is unused.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 3 clks, then release -> out_valid=0, in_ready=all 1s, busy=0.
- Channel 0, defaults, z=1000 -> out_valid 6 cycles after accept with out_x=500. Second z=1000 -> xp=499, zp=498, y=502, out_x=750.
- After reset, assert all 4 in_valid in one cycle with z=4000,8000,12000,16000 -> out_ch 0,1,2,3 at 6-cycle spacing, out_x=2000,4000,6000,8000.
- Channel 1, K=16'h7FFF, z=8388607 -> out_x=8388351. Then z=-8388608 -> y saturates to -8388608, out_x=-257.
- Clear during flight: start channel 2 with z=1000, write reg 3 on channel 2 at E3 -> out_x=500 emitted, x_prev[2] stays 0. Next z=1000 -> out_x=500.
- Reset at E3 mid-operation -> no out_valid, then reset values. With KSCHED_FIXED_PRIO_EN, channels 3 and 1 pending together -> channel 1 granted first.
